// File: rtl/pc_pkg.sv
// Shared types and control decode for the Hack PC with return-address stack.
package pc_pkg;

   localparam int unsigned PC_WIDTH = 16;
   localparam int unsigned PC_DEPTH = 8;

   typedef enum logic [2:0] {
      PC_HOLD    = 3'd0,
      PC_INC     = 3'd1,
      PC_LOAD    = 3'd2,
      PC_CALL    = 3'd3,
      PC_RET     = 3'd4,
      PC_CALLRET = 3'd5,
      PC_CLEAR   = 3'd6
   } pc_op_e;

   // clear > stall > {call,ret} > load > inc > hold
   function automatic pc_op_e decode_op(input logic clear, input logic stall,
                                        input logic call, input logic ret,
                                        input logic load, input logic inc);
      pc_op_e op;
      if (clear)              op = PC_CLEAR;
      else if (stall)         op = PC_HOLD;
      else if (call && ret)   op = PC_CALLRET;
      else if (call)          op = PC_CALL;
      else if (ret)           op = PC_RET;
      else if (load)          op = PC_LOAD;
      else if (inc)           op = PC_INC;
      else                    op = PC_HOLD;
      return op;
   endfunction

endpackage

// File: rtl/pc_stack_if.sv
// Control/status bundle between instruction decode and the PC block.
interface pc_stack_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned DW = $clog2(DEPTH) + 1;

   logic             clear;
   logic             stall;
   logic [WIDTH-1:0] in;
   logic             load;
   logic             inc;
   logic             call;
   logic             ret;
   logic [WIDTH-1:0] out;
   logic [DW-1:0]    depth;
   logic             full;
   logic             empty;
   logic             err;

   modport master (
      output clear, stall, in, load, inc, call, ret,
      input  out, depth, full, empty, err
   );

   modport slave (
      input  clear, stall, in, load, inc, call, ret,
      output out, depth, full, empty, err
   );
endinterface

// File: rtl/ret_stack.sv
// Return-address LIFO: push, pop and in-place replace of the top entry,
// with registered depth/full/empty and combinational fault indications.
module ret_stack #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned DW = AW + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] top_c,
   output logic [DW-1:0]    depth,
   output logic             full,
   output logic             empty,
   output logic             ovf_c,
   output logic             unf_c
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [DW-1:0]    depth_q, depth_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             wr_en;
   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    top_idx;

   assign top_idx = AW'(depth_q - DW'(1));
   assign top_c   = mem_q[top_idx];

   always_comb begin
      depth_d = depth_q;
      wr_en   = 1'b0;
      wr_idx  = AW'(depth_q);
      ovf_c   = push && !pop && full_q;
      unf_c   = pop && empty_q;
      if (clear) begin
         depth_d = '0;
      end else if (push && pop) begin
         // replace top in place; an empty stack is an underflow
         if (!empty_q) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
         end
      end else if (push) begin
         if (!full_q) begin
            wr_en   = 1'b1;
            depth_d = depth_q + DW'(1);
         end
      end else if (pop) begin
         if (!empty_q) depth_d = depth_q - DW'(1);
      end
      full_d  = (depth_d == DW'(DEPTH));
      empty_d = (depth_d == '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         depth_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         depth_q <= depth_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   // contents are don't-care after reset, so no reset on the array
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_idx] <= wdata;
   end

   assign depth = depth_q;
   assign full  = full_q;
   assign empty = empty_q;

endmodule

// File: rtl/pc_stack.sv
// Hack program counter with integrated return-address stack.
// Define PC_STACK_TRAP_EN to redirect stack overflow/underflow to TRAP_VECTOR.
module pc_stack
   import pc_pkg::*;
#(
   parameter int unsigned      WIDTH        = PC_WIDTH,
   parameter int unsigned      DEPTH        = PC_DEPTH,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [WIDTH-1:0] TRAP_VECTOR  = '1
) (
   input  logic     clk,
   input  logic     reset_n,
   pc_stack_if.slave bus
);

   localparam int unsigned DW = $clog2(DEPTH) + 1;

   pc_op_e           op;
   logic [WIDTH-1:0] out_q, out_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] ret_addr;
   logic [WIDTH-1:0] top_c;
   logic             ovf_c, unf_c;
   logic             st_push, st_pop, st_clear;
   logic [DW-1:0]    st_depth;
   logic             st_full, st_empty;

   assign op       = decode_op(bus.clear, bus.stall, bus.call, bus.ret, bus.load, bus.inc);
   assign ret_addr = out_q + WIDTH'(1);
   assign st_clear = (op == PC_CLEAR);
   assign st_push  = (op == PC_CALL) || (op == PC_CALLRET);
   assign st_pop   = (op == PC_RET)  || (op == PC_CALLRET);

   ret_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ret_stack (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (st_clear),
      .push    (st_push),
      .pop     (st_pop),
      .wdata   (ret_addr),
      .top_c   (top_c),
      .depth   (st_depth),
      .full    (st_full),
      .empty   (st_empty),
      .ovf_c   (ovf_c),
      .unf_c   (unf_c)
   );

   // next-PC select and sticky fault flag
   always_comb begin
      out_d = out_q;
      err_d = err_q | ovf_c | unf_c;
      unique case (op)
         PC_CLEAR: begin
            out_d = RESET_VECTOR;
            err_d = 1'b0;
         end
         PC_INC:  out_d = ret_addr;
         PC_LOAD: out_d = bus.in;
`ifdef PC_STACK_TRAP_EN
         PC_CALL:    out_d = ovf_c ? TRAP_VECTOR : bus.in;
         PC_RET:     out_d = unf_c ? TRAP_VECTOR : top_c;
         PC_CALLRET: out_d = unf_c ? TRAP_VECTOR : bus.in;
`else
         PC_CALL:    out_d = bus.in;
         PC_RET:     out_d = unf_c ? out_q : top_c;
         PC_CALLRET: out_d = unf_c ? out_q : bus.in;
`endif
         default: out_d = out_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q <= RESET_VECTOR;
         err_q <= 1'b0;
      end else begin
         out_q <= out_d;
         err_q <= err_d;
      end
   end

   assign bus.out   = out_q;
   assign bus.err   = err_q;
   assign bus.depth = st_depth;
   assign bus.full  = st_full;
   assign bus.empty = st_empty;

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised program counter for the Hack CPU family with an integrated hardware return-address stack (LIFO).
- Supports load/inc/reset like the base PC, plus call (push return address, jump) and ret (pop, jump).
- Sits between instruction decode and instruction ROM address; replaces the fixed 16-bit PC in designs that need subroutine support.

Parameters:
- WIDTH, 16, PC and stack entry width in bits (>=2)
- DEPTH, 8, return-stack entries (power of 2, >=2)
- RESET_VECTOR, 0, value of out after reset or clear
- TRAP_VECTOR, 2**WIDTH-1, jump target on stack fault (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous reset: out<=RESET_VECTOR, stack emptied, err cleared
- stall  in  1  freeze all state when high (clear still wins)
- in  in  WIDTH  load/call target address
- load  in  1  out<=in
- inc  in  1  out<=out+1
- call  in  1  push out+1, out<=in
- ret  in  1  out<=top of stack, pop
- out  out  WIDTH  current PC
- depth  out  $clog2(DEPTH)+1  number of valid stack entries
- full  out  1  depth==DEPTH
- empty  out  1  depth==0
- err  out  1  sticky stack fault flag

Behaviour:
- Async reset (reset_n low): out=RESET_VECTOR, depth=0, full=0, empty=1, err=0. Stack contents don't-care.
- All other updates happen on the rising clk edge. out/depth/full/empty/err are registered, 0-cycle combinational path from none of the inputs.
- Priority per cycle, highest first: clear > stall > {call,ret} > load > inc > hold.
- call only: push (out+1) mod 2^WIDTH; out<=in; depth+1.
- ret only: out<=top entry; depth-1.
- call&ret together: top entry replaced with (out+1) mod 2^WIDTH; depth unchanged; out<=in. Needs depth>=1; if empty, treated as underflow.
- load and inc are ignored whenever call or ret is high.
- Increment wraps: out=2^WIDTH-1 with inc gives 0. Pushed return address wraps identically.
- Overflow (call with full=1, ret=0): stack and depth unchanged (push dropped); err<=1; out per Optional Feature.
- Underflow (ret with empty=1): depth stays 0; err<=1; out per Optional Feature.
- err is sticky and cleared only by reset_n or clear.
- Reset mid-operation: reset_n asserted in any cycle discards pending op. clear in the same cycle as call/ret discards the op.
- Stack read is combinational from the top-of-stack register/array, so ret has single-cycle latency: out reflects the popped value the cycle after ret.

Optional Feature:
- Macro PC_STACK_TRAP_EN.
- Defined: on overflow or underflow, out<=TRAP_VECTOR and err<=1.
- Undefined: overflow gives out<=in (jump still taken, return address lost); underflow holds out unchanged; err<=1 in both cases.

Decomposition:
- Package pc_pkg: pc_op_e enum (PC_HOLD, PC_INC, PC_LOAD, PC_CALL, PC_RET, PC_CALLRET, PC_CLEAR), default WIDTH/DEPTH constants, and a priority-decode function mapping control inputs to pc_op_e.
- Sub-module ret_stack(WIDTH, DEPTH): storage array, stack pointer, push/pop/replace, full/empty, and an overflow/underflow indication.
- pc_stack holds the out register, next-PC mux and err flag.

Test Plan:
- Reset, then inc x3 -> out=0,1,2,3; depth=0; empty=1.
- out=0x0010, call in=0x0100 -> out=0x0100, depth=1, top=0x0011; then ret -> out=0x0011, depth=0.
- WIDTH=16, out=0xFFFF, inc -> out=0x0000. call at 0xFFFF -> pushed value 0x0000.
- DEPTH=8, 9 nested calls -> full=1 after the 8th call; 9th call sets err=1 and leaves depth=8. Check out=in without the macro, TRAP_VECTOR with it.
- ret with empty=1 -> err=1; out held (no macro) or TRAP_VECTOR (macro). clear -> err=0, out=RESET_VECTOR.
- stall with call=1 -> no change. call&ret with depth=2 and top=A, out=0x20, in=0x40 -> top=0x21, depth=2, out=0x40. reset_n pulse mid-sequence -> immediate out=RESET_VECTOR, depth=0.
